// File: rtl/spram_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spram_bus_pkg
//  Description : Shared constants and types for the SPRAM bus bridge
//                (address widths, default word count, response entry).
//  Revision    : 1.0 - initial release
// ============================================================================
package spram_bus_pkg;

   localparam int DEF_WORD_COUNT = 16000;
   localparam int BYTE_ADDR_W    = 16;
   localparam int WORD_ADDR_W    = 14;
   localparam int DATA_W         = 32;
   localparam int MASK_W         = 4;

   // One buffered read response: data word plus out-of-range flag.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              error;
   } rsp_entry_t;

endpackage
`default_nettype wire

// File: rtl/spram_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spram_rsp_fifo
//  Description : Small synchronous FIFO of read responses. Push and pop may
//                happen in the same cycle; an empty FIFO is not bypassed.
//                Depth need not be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module spram_rsp_fifo
   import spram_bus_pkg::*;
#(
   parameter  int RSP_DEPTH = 3,
   localparam int OCC_W     = $clog2(RSP_DEPTH + 1),
   localparam int PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  rsp_entry_t       push_entry,
   input  logic             pop,
   output logic [OCC_W-1:0] occupancy,
   output rsp_entry_t       head
);

   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RSP_DEPTH - 1);
   localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(RSP_DEPTH);

   rsp_entry_t       mem_q [0:RSP_DEPTH-1];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] count_q, count_d;
   logic             pop_ok;

   // Pointer advance with explicit wrap, and occupancy bookkeeping.
   always_comb begin
      pop_ok   = pop && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state; reset discards every buffered entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; data needs no reset since occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   // The credit scheme upstream must never let a push land on a full FIFO.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(push && !pop_ok && (count_q == FULL_OCC)));
      end
   end

   assign occupancy = count_q;
   assign head      = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/spram_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : spram_bus_bridge
//  Description : Valid/ready command front-end for a 1-cycle-latency SPRAM.
//                Drives RAM enables directly from the accepted command,
//                captures read data one cycle later into a response FIFO,
//                and filters out-of-range addresses. Credits (buffered plus
//                in-flight reads) bound FIFO occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module spram_bus_bridge
   import spram_bus_pkg::*;
#(
   parameter int WORD_COUNT = DEF_WORD_COUNT,
   parameter int RSP_DEPTH  = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_address,
   input  logic [31:0] cmd_data,
   input  logic [3:0]  cmd_mask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_error,
   output logic        err_oor_write,
   output logic        ram_en,
   output logic        ram_wr,
   output logic [13:0] ram_addr,
   output logic [3:0]  ram_mask,
   output logic [31:0] ram_wr_data,
   input  logic [31:0] ram_rd_data
);

   localparam int OCC_W = $clog2(RSP_DEPTH + 1);
   localparam logic [WORD_ADDR_W:0] WORD_LIMIT = (WORD_ADDR_W + 1)'(WORD_COUNT);
   localparam logic [OCC_W:0]       CREDITS    = (OCC_W + 1)'(RSP_DEPTH);

   logic                   inflight_q, inflight_d;
   logic                   inflight_oor_q, inflight_oor_d;
   logic                   err_oor_write_q, err_oor_write_d;
   logic [WORD_ADDR_W-1:0] word_addr;
   logic                   in_range;
   logic                   cmd_fire;
   logic                   rsp_pop;
   logic [OCC_W-1:0]       fifo_occ;
   rsp_entry_t             fifo_head;
   rsp_entry_t             push_entry;
   logic                   unused_addr_lsbs;

   // Byte-lane bits of the address carry no meaning for a word RAM.
   assign unused_addr_lsbs = &{1'b0, cmd_address[1:0]};

   // Command acceptance, RAM drive, read tracking and response selection.
   always_comb begin
      word_addr = cmd_address[15:2];
      in_range  = ({1'b0, word_addr} < WORD_LIMIT);

      // Ready depends on registered state only: buffered + in-flight reads.
      cmd_ready = !reset &&
                  (({1'b0, fifo_occ} + {{OCC_W{1'b0}}, inflight_q}) < CREDITS);
      cmd_fire  = cmd_valid && cmd_ready;

      ram_addr    = word_addr;
      ram_mask    = cmd_mask;
      ram_wr_data = cmd_data;
      ram_en      = cmd_fire && in_range;
      ram_wr      = cmd_fire && cmd_write && in_range;

      // Every read, legal or not, occupies one response slot to keep order.
      inflight_d      = cmd_fire && !cmd_write;
      inflight_oor_d  = cmd_fire && !cmd_write && !in_range;
      err_oor_write_d = err_oor_write_q || (cmd_fire && cmd_write && !in_range);

      push_entry.data  = inflight_oor_q ? '0 : ram_rd_data;
      push_entry.error = inflight_oor_q;

      rsp_valid = (fifo_occ != '0);
      rsp_data  = rsp_valid ? fifo_head.data  : '0;
      rsp_error = rsp_valid ? fifo_head.error : 1'b0;
      rsp_pop   = rsp_valid && rsp_ready;

      err_oor_write = err_oor_write_q;
   end

   // In-flight read marker and sticky write-error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_q      <= 1'b0;
         inflight_oor_q  <= 1'b0;
         err_oor_write_q <= 1'b0;
      end else begin
         inflight_q      <= inflight_d;
         inflight_oor_q  <= inflight_oor_d;
         err_oor_write_q <= err_oor_write_d;
      end
   end

   spram_rsp_fifo #(
      .RSP_DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (inflight_q),
      .push_entry (push_entry),
      .pop        (rsp_pop),
      .occupancy  (fifo_occ),
      .head       (fifo_head)
   );

endmodule
`default_nettype wire

// File: tb/tb_spram_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spram_bus_bridge
//  Description : Self-checking bench for spram_bus_bridge. A behavioural RAM
//                answers the bridge; an expected-response queue and a
//                reference memory predict every bus-visible output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spram_bus_bridge;

   localparam int WORD_COUNT = 16000;
   localparam int RSP_DEPTH  = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_write = 1'b0;
   logic [15:0] cmd_address = '0;
   logic [31:0] cmd_data = '0;
   logic [3:0]  cmd_mask = '0;
   logic        rsp_ready = 1'b0;
   logic [31:0] ram_rd_data = '0;
   logic        cmd_ready, rsp_valid, rsp_error, err_oor_write, ram_en, ram_wr;
   logic [31:0] rsp_data, ram_wr_data;
   logic [13:0] ram_addr;
   logic [3:0]  ram_mask;

   spram_bus_bridge #(.WORD_COUNT(WORD_COUNT), .RSP_DEPTH(RSP_DEPTH)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_address(cmd_address), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_error(rsp_error), .err_oor_write(err_oor_write),
      .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_mask(ram_mask),
      .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
   );

   always #5 clk = ~clk;

   // Behavioural SPRAM: byte-masked write, one-cycle registered read.
   bit [31:0] ram_mem [0:16383];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_wr) begin
            for (int b = 0; b < 4; b++)
               if (ram_mask[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
         end else begin
            ram_rd_data <= ram_mem[ram_addr];
         end
      end
   end

   // Reference model state.
   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   bit [31:0]   ref_mem [0:16383];
   logic        exp_oor = 1'b0;
   logic        hold_prev = 1'b0;
   logic [31:0] prev_data = '0;
   logic        prev_err = 1'b0;
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   int          last_fire_cyc = 0;
   int          last_pop_cyc = 0;
   logic [31:0] last_pop_data = '0;
   logic        last_pop_err = 1'b0;

   // One bus cycle: drive, check every output against the model, advance model.
   task automatic step(input logic v, input logic w, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] m, input logic rr,
                       output logic fired, output logic popped);
      logic        exp_ready, exp_valid, inr;
      logic [13:0] wa;
      exp_t        e;
      @(negedge clk);
      cmd_valid = v; cmd_write = w; cmd_address = a; cmd_data = d;
      cmd_mask = m; rsp_ready = rr;
      #1;
      wa  = a[15:2];
      inr = (int'(wa) < WORD_COUNT);
      exp_ready = (q.size() < RSP_DEPTH);
      exp_valid = (q.size() > 0) && (q[0].cyc <= cyc - 2);

      vectors++;
      if (cmd_ready !== exp_ready) begin
         miscompares++;
         $display("FAIL cmd_ready cyc=%0d: got %b expected %b", cyc, cmd_ready, exp_ready);
      end
      vectors++;
      if (rsp_valid !== exp_valid) begin
         miscompares++;
         $display("FAIL rsp_valid cyc=%0d: got %b expected %b", cyc, rsp_valid, exp_valid);
      end
      if (hold_prev) begin
         vectors++;
         if (rsp_valid !== 1'b1 || rsp_data !== prev_data || rsp_error !== prev_err) begin
            miscompares++;
            $display("FAIL rsp_hold cyc=%0d: got v=%b %h/%b expected v=1 %h/%b",
                     cyc, rsp_valid, rsp_data, rsp_error, prev_data, prev_err);
         end
      end
      fired = v && exp_ready;
      vectors++;
      if (ram_en !== (fired && inr) || ram_wr !== (fired && w && inr)) begin
         miscompares++;
         $display("FAIL ram_strobe cyc=%0d: got en=%b wr=%b expected en=%b wr=%b",
                  cyc, ram_en, ram_wr, fired && inr, fired && w && inr);
      end
      if (v) begin
         vectors++;
         if (ram_addr !== wa || ram_mask !== m || ram_wr_data !== d) begin
            miscompares++;
            $display("FAIL ram_bus cyc=%0d: got %h/%h/%h expected %h/%h/%h",
                     cyc, ram_addr, ram_mask, ram_wr_data, wa, m, d);
         end
      end
      vectors++;
      if (err_oor_write !== exp_oor) begin
         miscompares++;
         $display("FAIL err_oor_write cyc=%0d: got %b expected %b", cyc, err_oor_write, exp_oor);
      end

      popped = rsp_valid && rr;
      if (popped) begin
         last_pop_cyc  = cyc;
         last_pop_data = rsp_data;
         last_pop_err  = rsp_error;
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL stale_rsp cyc=%0d: got %h/%b expected no response", cyc, rsp_data, rsp_error);
         end else begin
            e = q.pop_front();
            if (rsp_data !== e.data || rsp_error !== e.err) begin
               miscompares++;
               $display("FAIL rsp_data cyc=%0d: got %h/%b expected %h/%b",
                        cyc, rsp_data, rsp_error, e.data, e.err);
            end
         end
      end
      hold_prev = rsp_valid && !rr;
      prev_data = rsp_data;
      prev_err  = rsp_error;

      if (fired) begin
         last_fire_cyc = cyc;
         if (w) begin
            if (inr) begin
               for (int b = 0; b < 4; b++)
                  if (m[b]) ref_mem[wa][8*b +: 8] = d[8*b +: 8];
            end else begin
               exp_oor = 1'b1;
            end
         end else begin
            e.data = inr ? ref_mem[wa] : 32'h0;
            e.err  = !inr;
            e.cyc  = cyc;
            q.push_back(e);
         end
      end
      cyc++;
   endtask

   // Hold reset for n cycles, then drop the model's buffered expectations.
   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
         #1;
         vectors++;
         if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready);
         end
         if (i > 0) begin
            vectors++;
            if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_error !== 1'b0 ||
                err_oor_write !== 1'b0 || ram_en !== 1'b0 || ram_wr !== 1'b0) begin
               miscompares++;
               $display("FAIL reset_outputs: got v=%b d=%h e=%b oor=%b en=%b wr=%b expected all 0",
                        rsp_valid, rsp_data, rsp_error, err_oor_write, ram_en, ram_wr);
            end
         end
      end
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      exp_oor   = 1'b0;
      hold_prev = 1'b0;
   endtask

   // Idle with rsp_ready high until the model expects nothing more.
   task automatic drain(output int npops);
      logic f, p;
      int   guard;
      npops = 0;
      guard = 0;
      while (q.size() != 0 && guard < 20) begin
         step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, f, p);
         if (p) npops++;
         guard++;
      end
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      end
   endtask

   task automatic test_reset();
      logic f, p;
      do_reset(3);
      step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, f, p);
   endtask

   task automatic test_write_read();
      logic f, p;
      int   n, fire_at;
      step(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b1, f, p);
      step(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 1'b1, f, p);
      fire_at = last_fire_cyc;
      vectors++;
      if (f !== 1'b1) begin
         miscompares++;
         $display("FAIL wr_rd_fire: got %b expected 1", f);
      end
      drain(n);
      vectors++;
      if (n != 1 || last_pop_data !== 32'hDEADBEEF || last_pop_err !== 1'b0 ||
          last_pop_cyc != fire_at + 2) begin
         miscompares++;
         $display("FAIL wr_rd: got n=%0d %h/%b lat=%0d expected 1 deadbeef/0 lat=2",
                  n, last_pop_data, last_pop_err, last_pop_cyc - fire_at);
      end
   endtask

   task automatic test_byte_mask();
      logic f, p;
      int   n;
      step(1'b1, 1'b1, 16'h0020, 32'h11223344, 4'hF, 1'b1, f, p);
      step(1'b1, 1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, 1'b1, f, p);
      step(1'b1, 1'b0, 16'h0020, 32'h0, 4'h0, 1'b1, f, p);
      drain(n);
      vectors++;
      if (last_pop_data !== 32'h11BB33DD || last_pop_err !== 1'b0) begin
         miscompares++;
         $display("FAIL byte_mask: got %h/%b expected 11bb33dd/0", last_pop_data, last_pop_err);
      end
   endtask

   task automatic test_out_of_range();
      logic f, p;
      int   n;
      step(1'b1, 1'b0, 16'hFA00, 32'h0, 4'h0, 1'b1, f, p);
      drain(n);
      vectors++;
      if (n != 1 || last_pop_data !== 32'h0 || last_pop_err !== 1'b1) begin
         miscompares++;
         $display("FAIL oor_read: got n=%0d %h/%b expected 1 00000000/1", n, last_pop_data, last_pop_err);
      end
      step(1'b1, 1'b1, 16'hFFFC, 32'h12345678, 4'hF, 1'b1, f, p);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, f, p);
      vectors++;
      if (err_oor_write !== 1'b1) begin
         miscompares++;
         $display("FAIL oor_write_sticky: got %b expected 1", err_oor_write);
      end
   endtask

   task automatic test_back_to_back();
      logic f, p;
      int   npops, first, last, nfire;
      npops = 0; first = 0; last = 0; nfire = 0;
      for (int i = 0; i < 24; i++) begin
         if (i < 10) begin
            step(1'b1, 1'b0, 16'($urandom_range(0, 63) << 2), 32'h0, 4'h0, 1'b1, f, p);
            if (f) nfire++;
         end else begin
            step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, f, p);
         end
         if (p) begin
            if (npops == 0) first = last_pop_cyc;
            last = last_pop_cyc;
            npops++;
         end
         if (i >= 10 && q.size() == 0) break;
      end
      vectors++;
      if (nfire != 10 || npops != 10 || last - first != 9) begin
         miscompares++;
         $display("FAIL back_to_back: got fires=%0d pops=%0d span=%0d expected 10 10 9",
                  nfire, npops, last - first);
      end
   endtask

   task automatic test_backpressure();
      logic f, p;
      int   nfire, n;
      nfire = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 16'($urandom_range(0, 63) << 2), 32'h0, 4'h0, 1'b0, f, p);
         if (f) nfire++;
      end
      vectors++;
      if (nfire != 3) begin
         miscompares++;
         $display("FAIL backpressure_fires: got %0d expected 3", nfire);
      end
      drain(n);
      vectors++;
      if (n != 3) begin
         miscompares++;
         $display("FAIL backpressure_pops: got %0d expected 3", n);
      end
   endtask

   task automatic test_reset_midop();
      logic f, p;
      int   nfire;
      nfire = 0;
      step(1'b1, 1'b1, 16'hFFFC, 32'h0, 4'hF, 1'b0, f, p);
      for (int i = 0; i < 6 && nfire < 3; i++) begin
         step(1'b1, 1'b0, 16'($urandom_range(0, 63) << 2), 32'h0, 4'h0, 1'b0, f, p);
         if (f) nfire++;
      end
      do_reset(2);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, f, p);
      vectors++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || err_oor_write !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_midop: got v=%b rdy=%b oor=%b expected 0 1 0",
                  rsp_valid, cmd_ready, err_oor_write);
      end
   endtask

   task automatic test_random();
      logic        f, p, v, w, rr;
      logic [15:0] a;
      int          sel, wd, n;
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6)      wd = $urandom_range(0, 7);
         else if (sel < 8) wd = $urandom_range(15990, 15999);
         else if (sel < 9) wd = $urandom_range(16000, 16010);
         else              wd = 16383;
         a  = {wd[13:0], 2'($urandom_range(0, 3))};
         v  = ($urandom_range(0, 9) < 7);
         w  = ($urandom_range(0, 9) < 4);
         rr = ($urandom_range(0, 9) < 6);
         step(v, w, a, $urandom, 4'($urandom_range(0, 15)), rr, f, p);
      end
      drain(n);
   endtask

   // Bound the whole run regardless of DUT behaviour.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write_read();
      test_byte_mask();
      test_out_of_range();
      test_back_to_back();
      test_backpressure();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
